// File: rtl/scr1_pulp_ram.sv
// PULP-protocol single-port RAM with a configurable grant stall and a fixed-latency response pipeline.
// Optional out-of-range error responses: define SCR1_PULP_RAM_RANGE_CHK_EN.
module scr1_pulp_ram #(
   parameter int unsigned                 SCR1_ADDR_WIDTH = 32,
   parameter int unsigned                 MEM_SIZE_BYTES  = 65536,
   parameter logic [SCR1_ADDR_WIDTH-1:0]  BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned                 RD_LATENCY      = 1,
   parameter int unsigned                 GNT_WAIT        = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_req_i,
   input  logic [SCR1_ADDR_WIDTH-1:0] data_addr_i,
   input  logic                       data_we_i,
   input  logic [3:0]                 data_be_i,
   input  logic [31:0]                data_wdata_i,
   output logic                       data_gnt_o,
   output logic                       data_rvalid_o,
   output logic [31:0]                data_rdata_o,
   output logic                       data_err_o
);

   localparam int unsigned WORDS      = MEM_SIZE_BYTES / 4;
   localparam int unsigned IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [2:0]  GNT_WAIT_C = 3'(GNT_WAIT);

   typedef enum logic {IDLE, STALL} state_t;

   state_t                     state, state_nxt;
   logic [2:0]                 wait_cnt, wait_cnt_nxt;

   logic [SCR1_ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]           word_idx;
   logic                       in_range;
   logic                       wr_en;
   logic                       rd_en;
   logic                       unused_offset;

   logic [31:0]                mem [WORDS];

   logic [RD_LATENCY-1:0]      pipe_vld;
   logic [RD_LATENCY-1:0]      pipe_err;
   logic [31:0]                pipe_data [RD_LATENCY];

   // Address decode: without the range check the offset simply wraps modulo the RAM size
   assign offset   = data_addr_i - BASE_ADDR;
   assign word_idx = (WORDS > 1) ? IDX_W'(offset >> 2) : '0;
`ifdef SCR1_PULP_RAM_RANGE_CHK_EN
   assign in_range = ({1'b0, offset} < (SCR1_ADDR_WIDTH+1)'(MEM_SIZE_BYTES));
`else
   assign in_range = 1'b1;
`endif
   assign unused_offset = ^offset;

   assign wr_en = data_gnt_o &  data_we_i & in_range;
   assign rd_en = data_gnt_o & ~data_we_i & in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         IDLE: begin
            if (data_req_i && !data_gnt_o) begin
               state_nxt    = STALL;
               wait_cnt_nxt = wait_cnt + 3'd1;
            end
         end
         STALL: begin
            // A dropped request is a protocol violation; restart the stall count
            if (data_gnt_o || !data_req_i) begin
               state_nxt    = IDLE;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt + 3'd1;
            end
         end
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      data_gnt_o = data_req_i && (wait_cnt == GNT_WAIT_C) && !rst;
   end

   // Storage has no reset: contents survive a reset of the control logic
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_err <= '0;
         for (int unsigned s = 0; s < RD_LATENCY; s++) begin
            pipe_data[s] <= '0;
         end
      end else begin
         pipe_vld[0]  <= data_gnt_o;
         pipe_err[0]  <= data_gnt_o & ~in_range;
         pipe_data[0] <= rd_en ? mem[word_idx] : '0;
         for (int unsigned s = 1; s < RD_LATENCY; s++) begin
            pipe_vld[s]  <= pipe_vld[s-1];
            pipe_err[s]  <= pipe_err[s-1];
            pipe_data[s] <= pipe_data[s-1];
         end
      end
   end

   assign data_rvalid_o = pipe_vld[RD_LATENCY-1];
   assign data_err_o    = pipe_err[RD_LATENCY-1];
   assign data_rdata_o  = pipe_data[RD_LATENCY-1];

endmodule

// File: tb/tb_scr1_pulp_ram.sv
// Scoreboard bench for scr1_pulp_ram: four instances cover latency, stall and address-window configurations.
// Expected responses carry their due cycle, so latency and ordering are checked together.
module tb_scr1_pulp_ram;

   localparam int unsigned NI = 4;
   localparam int unsigned LAT  [NI] = '{1, 3, 2, 1};
   localparam int unsigned GW   [NI] = '{0, 0, 2, 0};
   localparam int unsigned MSZ  [NI] = '{1024, 1024, 1024, 256};
   localparam logic [31:0] BASE [NI] = '{32'h0, 32'h0, 32'h0, 32'h1000};
`ifdef SCR1_PULP_RAM_RANGE_CHK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   typedef struct {
      int          inst;
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req    [NI];
   logic        we     [NI];
   logic [31:0] addr   [NI];
   logic [3:0]  be     [NI];
   logic [31:0] wdata  [NI];
   logic        gnt    [NI];
   logic        rvalid [NI];
   logic [31:0] rdata  [NI];
   logic        err    [NI];

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      scr1_pulp_ram #(
         .SCR1_ADDR_WIDTH (32),
         .MEM_SIZE_BYTES  (MSZ[g]),
         .BASE_ADDR       (BASE[g]),
         .RD_LATENCY      (LAT[g]),
         .GNT_WAIT        (GW[g])
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .data_req_i    (req[g]),
         .data_addr_i   (addr[g]),
         .data_we_i     (we[g]),
         .data_be_i     (be[g]),
         .data_wdata_i  (wdata[g]),
         .data_gnt_o    (gnt[g]),
         .data_rvalid_o (rvalid[g]),
         .data_rdata_o  (rdata[g]),
         .data_err_o    (err[g])
      );
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Called just after a rising edge; returns just after the grant edge with req still high
   task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int wait_cyc);
      exp_t e;
      req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = wd;
      for (int k = 0; k <= wait_cyc; k++) begin
         @(negedge clk);
         check_eq($sformatf("gnt%0d", i), 64'(gnt[i]), 64'(k == wait_cyc));
      end
      e.inst  = i;
      e.due   = cyc + int'(LAT[i]);
      e.rdata = w ? 32'h0 : exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < int'(NI); i++) req[i] = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Response monitor: every cycle each instance either owes a response or must be quiet
   always @(negedge clk) begin
      for (int i = 0; i < int'(NI); i++) begin
         int hit;
         hit = -1;
         for (int k = 0; k < sb.size(); k++)
            if (sb[k].inst == i && sb[k].due == cyc) hit = k;
         if (hit >= 0) begin
            check_eq($sformatf("rvalid%0d", i), 64'(rvalid[i]), 64'd1);
            check_eq($sformatf("rdata%0d", i), 64'(rdata[i]), 64'(sb[hit].rdata));
            check_eq($sformatf("err%0d", i), 64'(err[i]), 64'(sb[hit].err));
            sb.delete(hit);
         end else begin
            check_eq($sformatf("quiet%0d", i), 64'({rvalid[i], err[i], rdata[i]}), 64'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < int'(NI); i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
      end
      rst = 1'b1;

      // Reset: a pending request must not be granted
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; be[0] = 4'hF; wdata[0] = 32'h55;
      repeat (3) begin
         @(negedge clk);
         check_eq("gnt_in_reset", 64'(gnt[0]), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      issue(0, 1'b1, 32'h20, 4'hF, 32'h55, 32'h0, 1'b0, 0);

      // Byte-enable merge, zero-enable write, read-after-write, back-to-back grants
      issue(0, 1'b1, 32'h10, 4'hF, 32'hAABBCCDD, 32'h0, 1'b0, 0);
      issue(0, 1'b1, 32'h10, 4'h2, 32'h0000_1100, 32'h0, 1'b0, 0);
      issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hAABB11DD, 1'b0, 0);
      issue(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
      issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hAABB11DD, 1'b0, 0);
      issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h55, 1'b0, 0);
      idle(2);

      // Latency 3: back-to-back reads overlap the trailing write responses
      for (int k = 0; k < 4; k++)
         issue(1, 1'b1, 32'(4*k), 4'hF, 32'(k+1), 32'h0, 1'b0, 0);
      for (int k = 0; k < 4; k++)
         issue(1, 1'b0, 32'(4*k), 4'hF, 32'h0, 32'(k+1), 1'b0, 0);
      idle(4);

      // Reset while a response is in flight: it must never appear
      issue(1, 1'b0, 32'h0, 4'hF, 32'h0, 32'h1, 1'b0, 0);
      req[1] = 1'b0;
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      idle(5);

      // Grant stall of 2, dropped request restarts the count, held request stalls every time
      issue(2, 1'b1, 32'h40, 4'hF, 32'hCAFE, 32'h0, 1'b0, 2);
      req[2] = 1'b1; we[2] = 1'b0;
      @(negedge clk);
      check_eq("gnt2_drop", 64'(gnt[2]), 64'd0);
      @(posedge clk); #1;
      req[2] = 1'b0;
      @(negedge clk);
      check_eq("gnt2_noreq", 64'(gnt[2]), 64'd0);
      @(posedge clk); #1;
      issue(2, 1'b0, 32'h40, 4'hF, 32'h0, 32'hCAFE, 1'b0, 2);
      issue(2, 1'b0, 32'h40, 4'hF, 32'h0, 32'hCAFE, 1'b0, 2);
      idle(3);

      // Address window 0x1000..0x10FF: error responses or modulo wrap depending on the build
      issue(3, 1'b1, 32'h1000, 4'hF, 32'h11112222, 32'h0, 1'b0, 0);
      issue(3, 1'b1, 32'h10FC, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, 0);
      issue(3, 1'b1, 32'h0FFC, 4'hF, 32'h12345678, 32'h0, RC, 0);
      issue(3, 1'b0, 32'h10FC, 4'hF, 32'h0, RC ? 32'hA5A5A5A5 : 32'h12345678, 1'b0, 0);
      issue(3, 1'b0, 32'h1100, 4'hF, 32'h0, RC ? 32'h0 : 32'h11112222, RC, 0);
      issue(3, 1'b1, 32'h1100, 4'hF, 32'hDEADBEEF, 32'h0, RC, 0);
      issue(3, 1'b0, 32'h1000, 4'hF, 32'h0, RC ? 32'h11112222 : 32'hDEADBEEF, 1'b0, 0);
      idle(6);

      check_eq("drain", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
